contador_bcd: RTL and testbench



---
 rtl/contador_bcd.sv | 65 ++++++
 tb/tb_contador_bcd.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd.sv
// contador_bcd: 0.1 s prescaler and saturating 4-digit BCD stopwatch count (000.0..999.9)
module contador_bcd #(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 10,
  parameter int DIV = CLK_HZ / TICK_HZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] estado,
  input  logic       contando,
  input  logic       enable,
  output logic [3:0] decimos,
  output logic [3:0] unidades,
  output logic [3:0] dezenas,
  output logic [3:0] centenas,
  output logic       tick,
  output logic       limite
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d, inc;
  logic [2:0] ant_q, ant_d;
  logic tick_q, tick_d, lim_q, lim_d, sat_q, sat_d;
  logic run, clr, hold, cons, full, c;
  always_comb begin
    run = contando & enable & (estado == 3'd1);
    hold = (estado == 3'd2) | (estado == 3'd3);
    clr = (estado == 3'd0) | (estado > 3'd3) | ((estado == 3'd1) & (ant_q == 3'd3));
    full = cnt_q == 16'h9999;
    cons = tick_q & ~clr & ~hold;
    c = 1'b1;
    inc = cnt_q;
    for (int i = 0; i < 4; i++) begin
      inc[4*i+:4] = c ? (cnt_q[4*i+:4] == 4'd9 ? 4'd0 : cnt_q[4*i+:4] + 4'd1) : cnt_q[4*i+:4];
      c = c & (cnt_q[4*i+:4] == 4'd9);
    end
    // a tick consumed while paused, parado or saturated leaves the count untouched
    cnt_d = clr ? 16'h0 : (cons & ~full) ? inc : cnt_q;
    pre_d = clr ? '0 : ~run ? pre_q : (pre_q == PW'(DIV - 1)) ? '0 : pre_q + 1'b1;
    tick_d = ~clr & run & (pre_q == PW'(DIV - 1));
    lim_d = cons & full & ~sat_q;
    sat_d = ~clr & (sat_q | (cons & full));
    ant_d = estado;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      pre_q <= '0;
      tick_q <= 1'b0;
      lim_q <= 1'b0;
      sat_q <= 1'b0;
      ant_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      lim_q <= lim_d;
      sat_q <= sat_d;
      ant_q <= ant_d;
    end
  end
  assign {centenas, dezenas, unidades, decimos} = cnt_q;
  assign tick = tick_q;
  assign limite = lim_q;
endmodule

// File: tb/tb_contador_bcd.sv
// tb_contador_bcd: scenario tasks plus random run against an integer-count reference model
module tb_contador_bcd;
  logic clk = 1'b0, reset = 1'b0, contando = 1'b0, enable = 1'b0;
  logic [2:0] estado = 3'd0;
  logic [3:0] decimos, unidades, dezenas, centenas;
  logic tick, limite;
  logic [15:0] disp;
  int errors = 0, checks = 0;
  int m_cnt = 0, m_pre = 0, m_ant = 0;
  bit m_tick = 0, m_lim = 0, m_sat = 0;

  contador_bcd #(.CLK_HZ(40), .TICK_HZ(10)) dut (
    .clk(clk), .reset(reset), .estado(estado), .contando(contando), .enable(enable),
    .decimos(decimos), .unidades(unidades), .dezenas(dezenas), .centenas(centenas),
    .tick(tick), .limite(limite)
  );

  always #5 clk = ~clk;
  assign disp = {centenas, dezenas, unidades, decimos};

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // model: count held as tenths of a second, prescaler as a phase 0..3
  task automatic cyc(input logic [2:0] e, input bit c, input bit n);
    int e2;
    bit clr, hold, run, cons;
    estado = e; contando = c; enable = n;
    @(posedge clk);
    e2 = e > 3 ? 0 : int'(e);
    clr = e2 == 0 || (e2 == 1 && m_ant == 3);
    hold = e2 >= 2;
    run = c && n && e2 == 1;
    cons = m_tick && !clr && !hold;
    m_lim = cons && m_cnt == 9999 && !m_sat;
    m_sat = !clr && (m_sat || (cons && m_cnt == 9999));
    m_tick = !clr && run && m_pre == 3;
    m_pre = clr ? 0 : run ? (m_pre + 1) % 4 : m_pre;
    m_cnt = clr ? 0 : (cons && m_cnt < 9999) ? m_cnt + 1 : m_cnt;
    m_ant = int'(e);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    @(posedge clk);
    m_cnt = 0; m_pre = 0; m_ant = 0; m_tick = 0; m_lim = 0; m_sat = 0;
    #1;
    reset = 1'b1;
  endtask

  task automatic run_to(input int target, input int budget);
    int n = 0;
    while (m_cnt != target && n < budget) begin
      cyc(1, 1, 1);
      n++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({disp, tick, limite} !== 18'h0) begin errors++; $display("FAIL reset_init: got %h/%b/%b expected 0000/0/0", disp, tick, limite); end
    run_to(7, 100);
    checks++;
    if (disp !== 16'h0007) begin errors++; $display("FAIL reset_pre: got %h expected 0007", disp); end
    do_reset;
    checks++;
    if ({disp, tick, limite} !== 18'h0) begin errors++; $display("FAIL reset_mid: got %h/%b/%b expected 0000/0/0", disp, tick, limite); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1);
      checks++;
      if (tick !== (i == 3)) begin errors++; $display("FAIL reset_first_tick[%0d]: got %b expected %b", i, tick, i == 3); end
    end
  endtask

  task automatic test_count;
    cyc(0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 1);
      checks++;
      if (tick !== (i % 4 == 3) || disp !== bcd(m_cnt)) begin
        errors++; $display("FAIL count[%0d]: got tick=%b disp=%h expected tick=%b disp=%h", i, tick, disp, i % 4 == 3, bcd(m_cnt));
      end
    end
    checks++;
    if (disp !== 16'h0009) begin errors++; $display("FAIL count_pre_carry: got %h expected 0009", disp); end
    cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0010) begin errors++; $display("FAIL count_carry: got %h expected 0010", disp); end
  endtask

  task automatic test_pause;
    cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL pause_start: got %h expected 0001", disp); end
    for (int i = 0; i < 20; i++) begin
      cyc(2, 1, 0);
      checks++;
      if (disp !== 16'h0001 || tick !== 1'b0) begin errors++; $display("FAIL pause_hold[%0d]: got %h/%b expected 0001/0", i, disp, tick); end
    end
    cyc(1, 1, 1);
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL resume_1: got tick=%b expected 0", tick); end
    cyc(1, 1, 1);
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL resume_2: got tick=%b expected 1", tick); end
    cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0002) begin errors++; $display("FAIL resume_disp: got %h expected 0002", disp); end
  endtask

  task automatic test_parar;
    cyc(0, 0, 0);
    run_to(123, 1000);
    for (int i = 0; i < 50; i++) begin
      cyc(3, 0, 1);
      checks++;
      if (disp !== 16'h0123) begin errors++; $display("FAIL parar_hold[%0d]: got %h expected 0123", i, disp); end
    end
    cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL restart_clear: got %h expected 0000", disp); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1);
      checks++;
      if (tick !== (i == 3)) begin errors++; $display("FAIL restart_tick[%0d]: got %b expected %b", i, tick, i == 3); end
    end
    cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL restart_count: got %h expected 0001", disp); end
  endtask

  task automatic test_saturation;
    int pulses = 0;
    cyc(0, 0, 0);
    run_to(9998, 50000);
    checks++;
    if (disp !== 16'h9998) begin errors++; $display("FAIL sat_preload: got %h expected 9998", disp); end
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h9999) begin errors++; $display("FAIL sat_reach: got %h expected 9999", disp); end
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 1);
      pulses += int'(limite);
      checks++;
      if (disp !== 16'h9999 || limite !== m_lim) begin
        errors++; $display("FAIL sat_hold[%0d]: got %h/%b expected 9999/%b", i, disp, limite, m_lim);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL sat_pulses: got %0d expected 1", pulses); end
    cyc(0, 0, 0);
    checks++;
    if (disp !== 16'h0000 || limite !== 1'b0) begin errors++; $display("FAIL sat_clear: got %h/%b expected 0000/0", disp, limite); end
    for (int i = 0; i < 5; i++) cyc(1, 1, 1);
    checks++;
    if (disp !== 16'h0001) begin errors++; $display("FAIL sat_cleared_count: got %h expected 0001", disp); end
  endtask

  task automatic test_collision;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1);
    cyc(0, 1, 1);
    checks++;
    if ({disp, tick, limite} !== 18'h0) begin errors++; $display("FAIL collide_pre: got %h/%b/%b expected 0000/0/0", disp, tick, limite); end
    cyc(0, 1, 1);
    checks++;
    if (disp !== 16'h0000) begin errors++; $display("FAIL collide_after: got %h expected 0000", disp); end
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    cyc(0, 1, 1);
    checks++;
    if (disp !== 16'h0000 || limite !== 1'b0) begin errors++; $display("FAIL collide_tick: got %h/%b expected 0000/0", disp, limite); end
  endtask

  task automatic test_random;
    logic [2:0] e;
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      e = $urandom_range(0, 9) < 6 ? 3'd1 : 3'($urandom_range(0, 7));
      cyc(e, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      checks++;
      if ({disp, tick, limite} !== {bcd(m_cnt), m_tick, m_lim}) begin
        errors++; $display("FAIL random[%0d]: got %h/%b/%b expected %h/%b/%b", i, disp, tick, limite, bcd(m_cnt), m_tick, m_lim);
      end
    end
  endtask

  initial begin
    test_reset;
    test_count;
    test_pause;
    test_parar;
    test_collision;
    test_random;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
